// File: rtl/rv_decode_stage_pkg.sv
// Shared types for the RV32I/RV64I decode stage: opcodes, encoding formats,
// funct7 constants and the XLEN-independent part of the decoded bundle.
package rv_decode_stage_pkg;

  typedef enum logic [6:0] {
    OP_LUI      = 7'b0110111,
    OP_AUIPC    = 7'b0010111,
    OP_JAL      = 7'b1101111,
    OP_JALR     = 7'b1100111,
    OP_BRANCH   = 7'b1100011,
    OP_LOAD     = 7'b0000011,
    OP_STORE    = 7'b0100011,
    OP_IMMED    = 7'b0010011,
    OP_REGREG   = 7'b0110011,
    OP_MISC_MEM = 7'b0001111,
    OP_SYSTEM   = 7'b1110011,
    OP_IMMED32  = 7'b0011011,
    OP_REGREG32 = 7'b0111011
  } opcode_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded fields; the stage wraps these with its XLEN-wide pc and imm.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_t       fmt;
    logic       illegal;
  } dec_fields_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational instruction decoder: raw word -> fields, format,
// legality flag and sign-extended XLEN-wide immediate.
module rv_decode_comb
  import rv_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_fields_t     fields,
  output logic [XLEN-1:0] imm
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       illegal;
  fmt_t       fmt;
  logic       sh_l_ok;
  logic       sh_r_ok;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;

  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shift-immediate legality: RV64 has a 6-bit shamt, so only instr[31:26] is checked
  always_comb begin
    if (RV64) begin
      sh_l_ok = (instr[31:26] == F7_BASE[6:1]);
      sh_r_ok = (instr[31:26] == F7_BASE[6:1]) || (instr[31:26] == F7_ALT[6:1]);
    end else begin
      sh_l_ok = (f7 == F7_BASE);
      sh_r_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
    end
  end

  // Opcode -> format and legality; any illegal word is reported as I-format
  always_comb begin
    illegal = 1'b0;
    fmt     = FMT_I;
    case (opc)
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      OP_JAL:           fmt = FMT_J;
      OP_JALR:          illegal = (f3 != 3'b000);
      OP_LOAD:          illegal = RV64 ? (f3 == 3'b111) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
      OP_MISC_MEM, OP_SYSTEM: illegal = 1'b0;
      OP_IMMED: begin
        case (f3)
          3'b001:  illegal = !sh_l_ok;
          3'b101:  illegal = !sh_r_ok;
          default: illegal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        fmt     = FMT_B;
        illegal = (f3[2:1] == 2'b01);
      end
      OP_STORE: begin
        fmt     = FMT_S;
        illegal = RV64 ? (f3 > 3'b011) : (f3 > 3'b010);
      end
      OP_REGREG: begin
        fmt     = FMT_R;
        illegal = !((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OP_IMMED32: begin
        if (RV64) begin
          case (f3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = (f7 != F7_BASE);
            3'b101:  illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      OP_REGREG32: begin
        fmt = FMT_R;
        if (RV64) begin
          case (f3)
            3'b000, 3'b101: illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            3'b001:         illegal = (f7 != F7_BASE);
            default:        illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
    if (illegal) fmt = FMT_I;
  end

  // Immediate chosen by final format, then sign-extended to XLEN
  always_comb begin
    case (fmt)
      FMT_I:   imm_sel = imm_i;
      FMT_S:   imm_sel = imm_s;
      FMT_B:   imm_sel = imm_b;
      FMT_U:   imm_sel = imm_u;
      FMT_J:   imm_sel = imm_j;
      default: imm_sel = '0;
    endcase
  end

  assign imm = sext_xlen(imm_sel);

  assign fields = '{opcode:  opc,
                    rd:      instr[11:7],
                    rs1:     instr[19:15],
                    rs2:     instr[24:20],
                    funct3:  f3,
                    funct7:  f7,
                    fmt:     fmt,
                    illegal: illegal};

endmodule

// File: rtl/rv_decode_stage.sv
// Decode pipeline stage: combinational decode, one output register backed by
// a single skid entry (registered in_ready), and a saturating illegal counter.
module rv_decode_stage
  import rv_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] ill_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_fields_t     f;
  } bundle_t;

  dec_fields_t     dec_fields_p0;
  logic [XLEN-1:0] dec_imm_p0;
  bundle_t         dec_p0;

  bundle_t         out_p1, out_nxt;
  bundle_t         skid_p1, skid_nxt;
  logic            vld_p1, vld_nxt;
  logic            skid_vld_p1, skid_vld_nxt;
  logic            in_ready_p1;
  logic [CNT_W-1:0] ill_count_p1;
  logic            accept, xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rv_decode_comb #(.XLEN(XLEN)) u_comb (
    .instr  (in_instr),
    .fields (dec_fields_p0),
    .imm    (dec_imm_p0)
  );

  assign dec_p0 = '{pc: in_pc, imm: dec_imm_p0, f: dec_fields_p0};

  assign accept = in_valid && in_ready_p1;
  assign xfer   = vld_p1 && out_ready;

  // Next-state for output register and skid entry (FIFO order, skid drains first)
  always_comb begin
    out_nxt      = out_p1;
    vld_nxt      = vld_p1;
    skid_nxt     = skid_p1;
    skid_vld_nxt = skid_vld_p1;
    if (flush) begin
      vld_nxt      = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (!vld_p1 || out_ready) begin
      if (skid_vld_p1) begin
        out_nxt      = skid_p1;
        vld_nxt      = 1'b1;
        skid_vld_nxt = accept;
        if (accept) skid_nxt = dec_p0;
      end else begin
        vld_nxt = accept;
        if (accept) out_nxt = dec_p0;
      end
    end else if (accept) begin
      skid_nxt     = dec_p0;
      skid_vld_nxt = 1'b1;
    end
  end

  // ---- p0 -> p1: output register, valids, ready and counter ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_p1       <= '0;
      vld_p1       <= 1'b0;
      skid_vld_p1  <= 1'b0;
      in_ready_p1  <= 1'b1;
      ill_count_p1 <= '0;
    end else begin
      out_p1       <= out_nxt;
      vld_p1       <= vld_nxt;
      skid_vld_p1  <= skid_vld_nxt;
      in_ready_p1  <= !skid_vld_nxt;
      if (xfer && out_p1.f.illegal) ill_count_p1 <= sat_inc(ill_count_p1);
    end
  end

  // Skid data only matters while skid_vld_p1 is set, so it carries no reset
  always_ff @(posedge CLK) begin
    skid_p1 <= skid_nxt;
  end

  assign in_ready    = in_ready_p1;
  assign out_valid   = vld_p1;
  assign out_pc      = out_p1.pc;
  assign out_opcode  = out_p1.f.opcode;
  assign out_rd      = out_p1.f.rd;
  assign out_rs1     = out_p1.f.rs1;
  assign out_rs2     = out_p1.f.rs2;
  assign out_funct3  = out_p1.f.funct3;
  assign out_funct7  = out_p1.f.funct7;
  assign out_fmt     = out_p1.f.fmt;
  assign out_imm     = out_p1.imm;
  assign out_illegal = out_p1.f.illegal;
  assign ill_count   = ill_count_p1;

endmodule
